param_commit_ctrl: RTL
======================

Name: param_commit_ctrl

Overview:
- Central loader for runtime model parameters: gain, tau, gamma_dyn/sta, BDAMP, pps coefficients, i_gain_MN.
- Captures the host 32-bit word {ep02wire, ep01wire} into per-slot staging registers on trigger pulses.
- Commits all staged slots atomically on the next simulation tick, so the neuron pool, spindle and muscle never see a parameter change mid-step.
- Replaces per-trigger asynchronously clocked registers with one synchronous block in the clk1 domain.

Parameters:
- NSLOT, 16, number of parameter slots (one per trigger bit).
- W, 32, parameter word width.
- RESET_VALS, {NSLOT*W{1'b0}}, flattened per-slot reset values; slot i = bits [i*W +: W].

Ports:
- clk  in  1  system clock (clk1 domain).
- reset  in  1  synchronous, active-high reset.
- trig  in  NSLOT  one-cycle load pulses, already synchronised to clk; multiple bits may be set.
- data_in  in  W  word to stage for every slot whose trig bit is set.
- tick  in  1  one-cycle pulse marking a simulation-step boundary (sim_clk rising edge, synchronised).
- hold  in  1  while high, commits are deferred.
- params_flat  out  NSLOT*W  active parameter values; slot i at [i*W +: W].
- pending  out  NSLOT  slots staged but not yet committed.
- update_strobe  out  1  one-cycle pulse in the cycle after a commit edge.
- update_mask  out  NSLOT  slots written by the last commit; held until the next commit.
- overrun_cnt  out  8  count of re-triggers on already-pending slots; saturates at 255.

Behaviour:
- Reset, synchronous to clk: params_flat=RESET_VALS, stage regs=RESET_VALS, pending=0, update_strobe=0, update_mask=0, overrun_cnt=0, state=IDLE. Reset overrides all other inputs in the same cycle.
- Staging, any state:
  - For each i with trig[i]=1 at edge: stage[i]<=data_in and pending[i]<=1.
  - If pending[i] was already 1 and slot i is not being committed at that edge, overrun_cnt increments once per edge (saturating), regardless of how many bits overran.
- FSM states: IDLE, PENDING, STROBE.
  - IDLE: pending==0. Any trig -> PENDING. A tick in the same cycle is ignored, because a commit requires pending!=0 sampled before the edge.
  - PENDING: on tick=1 && hold=0, the commit edge does the following:
    - params[i]<=stage[i] for all i with pending[i]=1 (stage value before this edge).
    - update_mask<=pending.
    - pending<=trig, so a slot re-triggered in the same cycle stays pending with its new data and is not counted as overrun.
    - Go to STROBE.
  - PENDING: tick with hold=1 -> stay; the tick is dropped, not queued.
  - STROBE: update_strobe=1 for exactly this cycle. Next state is PENDING if pending!=0 (after this cycle's trig), else IDLE. A tick in STROBE is ignored.
- Latency: tick at cycle n (PENDING) -> new params_flat visible in cycle n+1; update_strobe high in n+1.
- Non-pending slots keep their active value across commits.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation (any state): all staged data discarded, params return to RESET_VALS.

Test Plan:
- Reset with RESET_VALS slot1=0x3F666666, slot5=0x42A00000 -> params_flat shows those values; pending=0, overrun_cnt=0, update_strobe=0.
- trig=0x0008, data_in=0x00000005 at cycle 10; tick at cycle 20 -> pending=0x0008 during cycles 11–20; slot3=5 from cycle 21; update_strobe=1 only in cycle 21; update_mask=0x0008; other slots unchanged.
- trig=0x0003 data 0xAAAA0000, then trig=0x0001 data 0x11110000 before tick -> after tick: slot0=0x11110000, slot1=0xAAAA0000, overrun_cnt=1.
- Slot 2 pending with 0x10; at the tick cycle trig=0x0004 data 0x20 -> slot2=0x10 after commit, pending=0x0004 afterwards, overrun_cnt unchanged; next tick -> slot2=0x20.
- hold=1 with slot 4 pending over 3 ticks -> no change and no strobe; hold=0 then tick -> commit. Separately, 300 back-to-back re-triggers on one slot -> overrun_cnt=255.
- Slot 6 pending, assert reset one cycle before tick -> slot6 remains RESET_VALS value, pending=0, no update_strobe.

Source files
------------

// File: rtl/param_commit_ctrl.sv
// param_commit_ctrl: stages host parameter words per slot and commits all staged slots atomically on a simulation tick
module param_commit_ctrl #(
  parameter int NSLOT = 16,
  parameter int W = 32,
  parameter logic [NSLOT*W-1:0] RESET_VALS = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSLOT-1:0]   trig,
  input  logic [W-1:0]       data_in,
  input  logic               tick,
  input  logic               hold,
  output logic [NSLOT*W-1:0] params_flat,
  output logic [NSLOT-1:0]   pending,
  output logic               update_strobe,
  output logic [NSLOT-1:0]   update_mask,
  output logic [7:0]         overrun_cnt
);
  typedef enum logic [1:0] {IDLE, PENDING, STROBE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] stage [NSLOT];
  logic commit, overrun;
  logic [NSLOT-1:0] pending_nxt;
  assign commit = state == PENDING && tick && !hold;
  assign overrun = !commit && |(trig & pending);
  assign pending_nxt = commit ? trig : pending | trig;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = commit ? STROBE : |pending_nxt ? PENDING : IDLE;
  always_comb update_strobe = state == STROBE;
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) stage[i] <= RESET_VALS[i*W +: W];
      params_flat <= RESET_VALS;
      pending <= '0;
      update_mask <= '0;
      overrun_cnt <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (trig[i]) stage[i] <= data_in;
        if (commit && pending[i]) params_flat[i*W +: W] <= stage[i];
      end
      pending <= pending_nxt;
      if (commit) update_mask <= pending;
      if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
endmodule
